// File: rtl/signed_sum_serial_rx_pkg.sv
// Shared defaults, accumulator sizing and FSM state encoding for the
// serial signed-sum receiver.
package sum_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N_OPS = 4;
  localparam int DEF_ACC_W = DEF_WIDTH + $clog2(DEF_N_OPS);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // Enough headroom that N_OPS worst-case operands can never wrap.
  function automatic int acc_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/signed_range_check.sv
// Flags a wide signed value that does not fit in WIDTH-bit two's complement.
module signed_range_check #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 6
) (
  input  logic signed [ACC_W-1:0] value_i,
  output logic                    ovf_o
);

  logic signed [WIDTH-1:0] low;

  // In range exactly when sign-extending the low bits reproduces the value.
  assign low   = value_i[WIDTH-1:0];
  assign ovf_o = (value_i != ACC_W'(low));

endmodule

// File: rtl/signed_sum_serial_rx.sv
// Accepts N_OPS signed operands over a valid/ready stream, sums them without
// wrap, and holds the result on an output valid/ready handshake.
module signed_sum_serial_rx
  import sum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_OPS = DEF_N_OPS
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clr,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [WIDTH-1:0]                  in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [WIDTH-1:0]                  sum,
  output logic signed [acc_width(WIDTH,N_OPS)-1:0] sum_full,
  output logic                                     overflow
);

  localparam int ACC_W = acc_width(WIDTH, N_OPS);
  localparam int CNT_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_OPS - 1);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    in_fire;
  logic                    out_fire;
  logic                    ovf_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;

    // clr wins over both handshakes; whatever was offered is dropped.
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (in_fire) begin
      acc_d = acc_q + ACC_W'(in_data);
      if (cnt_q == LAST) begin
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (out_fire) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  signed_range_check #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W)
  ) u_range_check (
    .value_i(acc_q),
    .ovf_o  (ovf_raw)
  );

  assign sum_full = acc_q;
  assign sum      = acc_q[WIDTH-1:0];
  assign overflow = out_valid && ovf_raw;

endmodule

// File: tb/tb_signed_sum_serial_rx.sv
// Directed bench for signed_sum_serial_rx with a result scoreboard.
module tb_signed_sum_serial_rx;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int AW = 6;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clr;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  sum;
  logic signed [AW-1:0] sum_full;
  logic                 overflow;

  int exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  signed_sum_serial_rx #(
    .WIDTH(W),
    .N_OPS(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .sum_full (sum_full),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int trunc4(input int v);
    logic signed [3:0] t;
    t = v[3:0];
    return int'(t);
  endfunction

  function automatic int ovf4(input int v);
    return (v > 7 || v < -8) ? 1 : 0;
  endfunction

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = 4'(d);
    chk("in_ready_before_send", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed4(input int a, input int b, input int c, input int d);
    int ops[4];
    int run;
    ops = '{a, b, c, d};
    run = 0;
    exp_q.push_back(a + b + c + d);
    for (int i = 0; i < 4; i++) begin
      send(ops[i]);
      run += ops[i];
      chk("running_sum_full", sum_full, run);
      if (i < 3) chk("out_valid_low_accum", out_valid, 0);
    end
    chk("out_valid_latency1", out_valid, 1);
  endtask

  task automatic collect();
    int n;
    int e;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("out_valid_wait", out_valid, 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("sum_full", sum_full, e);
      chk("sum", sum, trunc4(e));
      chk("overflow", overflow, ovf4(e));
      chk("in_ready_done", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
    chk("sum_full_after_hs", sum_full, 0);
    chk("overflow_after_hs", overflow, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_sum_full", sum_full, 0);
    chk("rst_sum", sum, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3,2,-1,1 with out_ready held high throughout
    out_ready = 1'b1;
    feed4(3, 2, -1, 1);
    collect();

    feed4(7, 4, 3, -2);
    collect();
    feed4(-8, -4, -1, 7);
    collect();

    // Result held 5 cycles while operands keep being offered
    feed4(-6, -3, -2, -1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'($urandom);
      @(posedge clk);
      #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_sum_full", sum_full, -12);
      chk("hold_sum", sum, 4);
      chk("hold_overflow", overflow, 1);
    end
    in_valid = 1'b0;
    collect();

    feed4(0, 0, 0, 0);
    collect();

    // clr beats a simultaneous input handshake
    send(5);
    send(5);
    chk("partial_before_clr", sum_full, 10);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'sd3;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_sum_full", sum_full, 0);
    chk("clr_in_ready", in_ready, 1);
    feed4(1, 2, 3, 4);
    collect();

    // clr beats a simultaneous output handshake; result is dropped
    feed4(1, 1, 1, 1);
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    clr       = 1'b1;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    out_ready = 1'b0;
    chk("clr_done_out_valid", out_valid, 0);
    chk("clr_done_sum_full", sum_full, 0);

    // Asynchronous reset mid-sum
    send(2);
    send(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sum_full", sum_full, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    feed4(1, 1, 1, 1);
    collect();

    // Asynchronous reset while holding a result
    feed4(7, 7, 7, 7);
    void'(exp_q.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_done_out_valid", out_valid, 0);
    chk("rst_done_sum_full", sum_full, 0);
    chk("rst_done_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    feed4(-1, -2, 3, 1);
    collect();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
